// File: rtl/wb_pkg.sv
// Shared constants and types for the Wishbone FIFO slave:
// register offsets, CTRL/STATUS bit positions and the FSM state type.
package wb_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;

  localparam int CTRL_INV_BIT   = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STAT_FULL_BIT  = 30;
  localparam int STAT_EMPTY_BIT = 31;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/wb_sfifo.sv
// Synchronous FIFO with occupancy count; clr empties it and wins over push/pop.
// Pointers wrap modulo DEPTH; the count saturates because push/pop are qualified.
module wb_sfifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full & ~i_clr;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone B4 pipelined slave exposing a FIFO through DATA/STATUS/CTRL registers,
// with an optional write-latency wait state on DATA pushes.
//
//   state | meaning
//   IDLE  | accept any request, respond next cycle (or enter WAIT for a delayed push)
//   WAIT  | stall high, count down the push latency, then commit and respond
module wb_fifo_slave
  import wb_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter int            DEPTH     = 4,
  parameter int            WR_LAT    = 1,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic            o_wb_stall
);

  localparam int         CW       = $clog2(DEPTH + 1);
  localparam logic [3:0] LAT_LOAD = 4'((WR_LAT > 0) ? WR_LAT - 1 : 0);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wcnt;
  logic [3:0]    w_wcnt_nxt;
  logic          r_ack;
  logic          w_ack_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_nxt;
  logic [DW-1:0] r_pend;
  logic [DW-1:0] w_pend_nxt;
  logic          r_inv;
  logic          w_inv_nxt;

  logic          w_req;
  logic          w_hit;
  logic [1:0]    w_ofs;
  logic          w_bad;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_push_word;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_ctrl_rd;

  logic          w_push;
  logic          w_pop;
  logic          w_clr;
  logic [DW-1:0] w_fifo_din;
  logic [DW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_unused;

  assign w_unused   = ^i_wb_addr[1:0];
  assign o_wb_stall = (r_state == WAIT);
  assign w_req      = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign w_hit      = (i_wb_addr[AW-1:4] == BASE_ADDR[AW-1:4]);
  assign w_ofs      = i_wb_addr[3:2];

  // A dropped cycle suppresses the visible response, never the side effect.
  assign o_wb_ack   = r_ack & i_wb_cyc;
  assign o_wb_err   = r_err & i_wb_cyc;
  assign o_wb_data  = r_data;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DW / 8; b++) begin
      w_mask[b*8 +: 8] = {8{i_wb_sel[b]}};
    end
  end

  assign w_wdata     = i_wb_data & w_mask;
  assign w_push_word = r_inv ? ~w_wdata : w_wdata;

  always_comb begin
    w_status                 = '0;
    w_status[CW-1:0]         = w_count;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_ctrl_rd                = '0;
    w_ctrl_rd[CTRL_INV_BIT]  = r_inv;
  end

  // Full/empty errors are judged on occupancy at acceptance.
  assign w_bad = ~w_hit
               | (w_ofs == OFS_RSVD)
               | (i_wb_we & (w_ofs == OFS_STATUS))
               | ((w_ofs == OFS_DATA) &  i_wb_we & w_full)
               | ((w_ofs == OFS_DATA) & ~i_wb_we & w_empty);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_data_nxt  = r_data;
    w_pend_nxt  = r_pend;
    w_inv_nxt   = r_inv;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_fifo_din  = w_push_word;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            case (w_ofs)
              OFS_DATA: begin
                if (i_wb_we) begin
                  if (WR_LAT == 0) begin
                    w_push    = 1'b1;
                    w_ack_nxt = 1'b1;
                  end else begin
                    w_state_nxt = WAIT;
                    w_wcnt_nxt  = LAT_LOAD;
                    w_pend_nxt  = w_push_word;
                  end
                end else begin
                  w_pop      = 1'b1;
                  w_ack_nxt  = 1'b1;
                  w_data_nxt = w_head;
                end
              end
              OFS_STATUS: begin
                w_ack_nxt  = 1'b1;
                w_data_nxt = w_status;
              end
              OFS_CTRL: begin
                w_ack_nxt = 1'b1;
                if (i_wb_we) begin
                  w_inv_nxt = w_wdata[CTRL_INV_BIT];
                  w_clr     = w_wdata[CTRL_CLR_BIT];
                end else begin
                  w_data_nxt = w_ctrl_rd;
                end
              end
              default: w_err_nxt = 1'b1;
            endcase
          end
        end
      end
      WAIT: begin
        w_fifo_din = r_pend;
        if (r_wcnt == 4'd0) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_pend  <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_data  <= w_data_nxt;
      r_pend  <= w_pend_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  wb_sfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .i_data  (w_fifo_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
